// File: rtl/audio_envelope_reconstructor_pkg.sv
// Shared definitions for the envelope reconstructor.
//   SAMPLE_W : sample / envelope width (signed two's complement)
//   LEN_W    : width of interval length and interval count
//   MODE_*   : playback mode encodings
//   state_t  : control FSM states
package audio_env_pkg;
  localparam int SAMPLE_W = 32;
  localparam int LEN_W    = 16;

  localparam logic MODE_ALT = 1'b0;
  localparam logic MODE_MID = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EMIT
  } state_t;
endpackage

// File: rtl/audio_envelope_reconstructor_env_sample_gen.sv
// Combinational sample selector.
//   min_val, max_val, mid_val : registered envelope pair and its midpoint
//   mode                      : MODE_ALT alternates max/min, MODE_MID emits mid
//   k_odd                     : LSB of the in-interval sample index
//   sample                    : selected output sample
module env_sample_gen
  import audio_env_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0] min_val,
  input  logic signed [SAMPLE_W-1:0] max_val,
  input  logic signed [SAMPLE_W-1:0] mid_val,
  input  logic                       mode,
  input  logic                       k_odd,
  output logic signed [SAMPLE_W-1:0] sample
);

  always_comb begin
    sample = max_val;
    if (mode == MODE_MID) begin
      sample = mid_val;
    end else if (k_odd) begin
      sample = min_val;
    end
  end

endmodule

// File: rtl/audio_envelope_reconstructor.sv
// Regenerates a sample-rate stream from per-interval (min, max) envelope
// pairs, interval_len samples per pair, under valid/ready flow control.
//   clk, reset                  : clock, async active-high reset
//   start, interval_len,
//   num_intervals, mode         : job request, latched in IDLE
//   env_valid/env_ready,
//   env_min/env_max             : envelope pair input stream
//   out_valid/out_ready,
//   out_sample/out_last         : reconstructed sample output stream
//   busy, done                  : job status; done is a one-cycle pulse
module audio_envelope_reconstructor
  import audio_env_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [LEN_W-1:0]           interval_len,
  input  logic [LEN_W-1:0]           num_intervals,
  input  logic                       mode,
  input  logic                       env_valid,
  input  logic signed [SAMPLE_W-1:0] env_min,
  input  logic signed [SAMPLE_W-1:0] env_max,
  output logic                       env_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [SAMPLE_W-1:0] out_sample,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

  state_t state, state_nxt;

  logic [LEN_W-1:0]           len_q;
  logic [LEN_W-1:0]           nint_q;
  logic [LEN_W-1:0]           int_cnt;
  logic [LEN_W-1:0]           k;
  logic                       mode_q;
  logic                       done_q;
  logic signed [SAMPLE_W-1:0] min_p0;
  logic signed [SAMPLE_W-1:0] max_p0;
  logic signed [SAMPLE_W-1:0] mid_p0;

  logic hs;
  logic end_int;
  logic last_int;
  logic load;

  // Sum at one extra bit so (min + max) never wraps; dropping the LSB is an
  // arithmetic shift right, i.e. rounding toward minus infinity.
  function automatic logic signed [SAMPLE_W-1:0] midpoint(
    input logic signed [SAMPLE_W-1:0] a,
    input logic signed [SAMPLE_W-1:0] b
  );
    logic signed [SAMPLE_W:0] sum;
    sum = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
    return sum[SAMPLE_W:1];
  endfunction

  assign out_valid = (state == EMIT);
  assign busy      = (state != IDLE);
  assign done      = done_q;

  assign hs       = out_valid && out_ready;
  assign last_int = (int_cnt == nint_q - LEN_W'(1));
  assign end_int  = hs && (k == len_q - LEN_W'(1));
  assign out_last = out_valid && (k == len_q - LEN_W'(1)) && last_int;

  // Ready is also raised on the closing handshake of a non-final interval so
  // the next pair can load without a bubble; this is the only path from
  // out_ready to an output.
  assign env_ready = (state == FETCH) || (end_int && !last_int);
  assign load      = env_ready && env_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (num_intervals == '0) ? IDLE : FETCH;
        end
      end
      FETCH: begin
        if (env_valid) begin
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (end_int) begin
          if (last_int) begin
            state_nxt = IDLE;
          end else if (env_valid) begin
            state_nxt = EMIT;
          end else begin
            state_nxt = FETCH;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: control state, counters and the captured envelope pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      len_q   <= '0;
      nint_q  <= '0;
      int_cnt <= '0;
      k       <= '0;
      mode_q  <= MODE_ALT;
      done_q  <= 1'b0;
      min_p0  <= '0;
      max_p0  <= '0;
      mid_p0  <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= 1'b0;

      if ((state == IDLE) && start) begin
        len_q   <= (interval_len == '0) ? LEN_W'(1) : interval_len;
        nint_q  <= num_intervals;
        mode_q  <= mode;
        int_cnt <= '0;
        k       <= '0;
        done_q  <= (num_intervals == '0);
      end

      if (load) begin
        min_p0 <= env_min;
        max_p0 <= env_max;
        mid_p0 <= midpoint(env_min, env_max);
        k      <= '0;
      end else if (hs) begin
        k <= k + LEN_W'(1);
      end

      if (end_int) begin
        if (last_int) begin
          done_q <= 1'b1;
        end else begin
          int_cnt <= int_cnt + LEN_W'(1);
        end
      end
    end
  end

  env_sample_gen u_gen (
    .min_val (min_p0),
    .max_val (max_p0),
    .mid_val (mid_p0),
    .mode    (mode_q),
    .k_odd   (k[0]),
    .sample  (out_sample)
  );

endmodule

// File: tb/tb_audio_envelope_reconstructor.sv
module tb_audio_envelope_reconstructor;
  import audio_env_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       start;
  logic [LEN_W-1:0]           interval_len;
  logic [LEN_W-1:0]           num_intervals;
  logic                       mode;
  logic                       env_valid;
  logic signed [SAMPLE_W-1:0] env_min;
  logic signed [SAMPLE_W-1:0] env_max;
  logic                       env_ready;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [SAMPLE_W-1:0] out_sample;
  logic                       out_last;
  logic                       busy;
  logic                       done;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [SAMPLE_W-1:0] s;
    logic                l;
  } exp_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] mn;
    logic [SAMPLE_W-1:0] mx;
  } pair_t;

  exp_t  exp_q[$];
  pair_t pairs[$];

  logic                held_v   = 1'b0;
  logic [SAMPLE_W-1:0] held_s   = '0;
  logic                held_l   = 1'b0;
  logic                done_exp = 1'b0;
  exp_t                mon_e;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  audio_envelope_reconstructor dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .interval_len  (interval_len),
    .num_intervals (num_intervals),
    .mode          (mode),
    .env_valid     (env_valid),
    .env_min       (env_min),
    .env_max       (env_max),
    .env_ready     (env_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sample    (out_sample),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done)
  );

  // Output monitor: scoreboard pops, stall stability, done pulse model.
  always @(negedge clk) begin
    if (reset) begin
      held_v   <= 1'b0;
      done_exp <= 1'b0;
    end else begin
      if (done || done_exp) check("done_pulse", done, done_exp);
      if (done) check("busy_low_at_done", busy, 1'b0);
      if (held_v) check("stall_hold", {out_valid, $unsigned(out_sample), out_last}, {1'b1, held_s, held_l});
      if (out_valid && env_ready) check("env_ready_only_on_handshake", out_ready, 1'b1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_sample", out_valid, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check("sample", $unsigned(out_sample), mon_e.s);
          check("last_flag", out_last, mon_e.l);
        end
      end
      held_v   <= out_valid && !out_ready;
      held_s   <= out_sample;
      held_l   <= out_last;
      done_exp <= (out_valid && out_ready && out_last) ||
                  (start && !busy && (num_intervals == '0));
    end
  end

  function automatic pair_t mk(input int a, input int b);
    pair_t p;
    p.mn = a;
    p.mx = b;
    return p;
  endfunction

  task automatic load_scn1();
    pairs.delete();
    pairs.push_back(mk(-100, 100));
    pairs.push_back(mk(0, 9));
    pairs.push_back(mk(42, 42));
  endtask

  // Runs one job; expectations are pushed before the start pulse.
  task automatic run(input int len, input int n, input logic md, input bit toggle,
                     input int gap, input int abort_after, input int start_at,
                     output int hs, output int span);
    int     len_e, idx, wctr, first, lastc;
    bit     acc, prev_acc, done_seen, expired;
    longint sm;
    exp_t   e;
    len_e = (len == 0) ? 1 : len;
    for (int i = 0; i < n; i++) begin
      sm = longint'($signed(pairs[i].mn)) + longint'($signed(pairs[i].mx));
      for (int s = 0; s < len_e; s++) begin
        if (md) e.s = SAMPLE_W'(sm >>> 1);
        else    e.s = (s % 2 == 1) ? pairs[i].mn : pairs[i].mx;
        e.l = (i == n - 1) && (s == len_e - 1);
        exp_q.push_back(e);
      end
    end
    idx = 0; wctr = 0; hs = 0; first = -1; lastc = -1; prev_acc = 0; done_seen = 0;
    expired = 1;
    @(posedge clk); #1;
    interval_len  = LEN_W'(len);
    num_intervals = LEN_W'(n);
    mode          = md;
    start         = 1'b1;
    out_ready     = 1'b1;
    env_valid     = (n > 0);
    if (n > 0) begin
      env_min = pairs[0].mn;
      env_max = pairs[0].mx;
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    if (n > 0) check("start_to_env_ready", env_ready, 1'b1);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (prev_acc) check("pair_to_out_valid", out_valid, 1'b1);
      acc = env_valid && env_ready;
      if (out_valid && first < 0) first = cyc;
      if (out_valid && out_ready) begin
        hs++;
        lastc = cyc;
      end
      if (done) begin
        done_seen = 1;
        expired   = 0;
        break;
      end
      if (abort_after > 0 && hs == abort_after) begin
        expired = 0;
        break;
      end
      prev_acc = acc;
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) begin
        idx++;
        wctr = gap;
      end
      env_valid = (idx < n) && (wctr == 0);
      if (idx < n) begin
        env_min = pairs[idx].mn;
        env_max = pairs[idx].mx;
      end
      if (wctr > 0) wctr--;
      out_ready = toggle ? ~out_ready : 1'b1;
      if (cyc == start_at) begin
        start         = 1'b1;
        interval_len  = 16'd3;
        num_intervals = 16'd1;
        mode          = ~md;
      end
      @(negedge clk);
    end
    check("wait_not_expired", expired, 1'b0);
    if (abort_after == 0) begin
      check("done_reached", done_seen, 1'b1);
      check("queue_drained", exp_q.size(), 0);
    end
    span      = lastc - first;
    env_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int hs, span;
    reset = 1'b1; start = 1'b0; interval_len = '0; num_intervals = '0; mode = MODE_ALT;
    env_valid = 1'b0; env_min = '0; env_max = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_env_ready", env_ready, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_out_sample", out_sample, 32'sd0);
    reset = 1'b0;

    // ALT, no backpressure: 30 samples back to back
    load_scn1();
    run(10, 3, MODE_ALT, 0, 0, 0, -1, hs, span);
    check("alt_count", hs, 30);
    check("alt_no_bubbles_span", span, 29);

    // MID rounding toward -inf and no overflow at full scale
    pairs.delete();
    pairs.push_back(mk(-3, 0));
    pairs.push_back(mk(32'h7FFFFFFF, 32'h7FFFFFFF));
    run(2, 2, MODE_MID, 0, 0, 0, -1, hs, span);
    check("mid_count", hs, 4);

    // Backpressure plus 3-cycle envelope starvation
    load_scn1();
    run(10, 3, MODE_ALT, 1, 3, 0, -1, hs, span);
    check("bp_count", hs, 30);

    // Zero intervals: immediate done, no samples
    pairs.delete();
    run(4, 0, MODE_ALT, 0, 0, 0, -1, hs, span);
    check("zero_int_count", hs, 0);

    // Zero length acts as one sample per interval
    pairs.delete();
    pairs.push_back(mk(-5, 7));
    pairs.push_back(mk(1, 2));
    run(0, 2, MODE_ALT, 0, 0, 0, -1, hs, span);
    check("len0_count", hs, 2);

    // Reset after 5 samples, then a clean rerun
    load_scn1();
    run(10, 3, MODE_ALT, 0, 0, 5, -1, hs, span);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_env_ready", env_ready, 1'b0);
    check("abort_out_last", out_last, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_out_sample", out_sample, 32'sd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", done, 1'b0);
    run(10, 3, MODE_ALT, 0, 0, 0, -1, hs, span);
    check("rerun_count", hs, 30);

    // Start pulse during EMIT must be ignored
    load_scn1();
    run(10, 3, MODE_ALT, 0, 0, 0, 15, hs, span);
    check("ignored_start_count", hs, 30);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
